param_data_memory: RTL and testbench
====================================

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits; legal 4..32.
REQ-002 Parameter DEPTH, default 32, number of words; even, legal 2..1024, not necessarily a power of two.
REQ-003 Parameter ADDR_WIDTH, default clog2(DEPTH), address width in bits; derived, never overridden.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 clear_n  input  1  reset; asynchronous assert, active-low.
REQ-006 signal_memread  input  1  read request, sampled each cycle.
REQ-007 signal_memwrite  input  1  write request, sampled each cycle.
REQ-008 address  input  ADDR_WIDTH  word address for read and write.
REQ-009 data_to_write  input  DATA_WIDTH  write data.
REQ-010 data_out  output  DATA_WIDTH  registered read data.
REQ-011 data_valid  output  1  one-cycle pulse; data_out holds fresh read data.
REQ-012 busy  output  1  high while the preset sequencer runs; requests are not accepted.
REQ-013 reject  output  1  one-cycle pulse; a request arrived while busy.
REQ-014 addr_error  output  1  one-cycle pulse; a request with address >= DEPTH arrived while not busy.

Function
REQ-015 Two states: INIT and READY. INIT is entered on reset; READY is entered after the preset completes and persists until the next reset.
REQ-016 INIT behaviour: an index counter runs 0..DEPTH-1 and writes one word per cycle.
  - Index i < DEPTH/2 receives i, zero-extended.
  - Index DEPTH/2+k receives -k in two's complement, truncated to DATA_WIDTH.
REQ-017 INIT duration: exactly DEPTH cycles after clear_n deasserts. busy falls in the cycle after index DEPTH-1 is written.
REQ-018 Read in READY with a legal address: data_out = memory[address] and data_valid = 1 in the next cycle. Latency is 1 and fixed.
REQ-019 Write in READY with a legal address: memory[address] = data_to_write, visible to a read issued the following cycle.
REQ-020 Read and write in the same READY cycle are both performed. A read and write to the same address return the old data (read-before-write), and the new data is stored.
REQ-021 A request in INIT is discarded, with no read and no write.
  - reject pulses next cycle.
  - data_valid stays 0.
  - Sequencer progress is unaffected.
REQ-022 A request with address >= DEPTH in READY is discarded.
  - addr_error pulses next cycle.
  - data_out holds its value and data_valid stays 0.
  - If the same cycle also carries the other request type, that request is discarded too.
REQ-023 data_out holds its last value whenever data_valid is 0.
REQ-024 reject and addr_error are never asserted in the same cycle. With no request, both are 0.

Reset
REQ-025 clear_n low immediately forces the block to its reset condition, regardless of whether it is in INIT or READY.
  - State INIT, index 0.
  - data_out = 0, data_valid = 0, busy = 1, reject = 0, addr_error = 0.
REQ-026 Memory contents are not cleared asynchronously. They are rewritten by the INIT sequence after clear_n rises, so every prior write is overwritten.
REQ-027 Reset asserted mid-INIT restarts the sequence from index 0. Reset asserted mid-write discards that write.

Structure
REQ-028 A shared package param_data_memory_pkg holds the following; the port list holds neither.
  - The state enumeration (INIT, READY).
  - The preset-value function (index, DEPTH, DATA_WIDTH -> word).
REQ-029 Storage is a single sub-module param_data_memory_array: DEPTH x DATA_WIDTH, one synchronous write port and one synchronous read port, no reset, inferable as block RAM.
REQ-030 The sequencer, request qualification and flag generation reside in param_data_memory. This top level alone drives the array's write port mux (INIT writes vs user writes).

Verification (DATA_WIDTH=8, DEPTH=32 unless noted)
REQ-031 Release clear_n, hold all requests low -> busy = 1 for exactly 32 cycles. Then read address 17 -> data_out = 8'hFF with data_valid next cycle; read address 5 -> 8'h05; read address 31 -> 8'hF1.
REQ-032 Write 8'hA5 to address 3, then read address 3 next cycle -> data_out = 8'hA5, data_valid = 1.
REQ-033 Read and write address 5 in the same cycle with data_to_write 8'h3C -> data_out = 8'h05. A following read of address 5 -> 8'h3C.
REQ-034 Read and write during INIT cycle 10 -> reject pulses once, data_valid = 0, busy still falls at cycle 32. The write has no effect: address 0 reads 8'h00.
REQ-035 After writing 8'hA5 to address 3, pulse clear_n low mid-INIT of a second sequence -> busy lasts 32 cycles from the final release, and address 3 reads 8'h03.
REQ-036 DEPTH=24: read address 30 -> addr_error pulse, data_valid = 0, data_out unchanged. Read address 12 -> 8'h00. Read address 23 -> 8'hF5.

Source files
------------

// File: rtl/param_data_memory_pkg.sv
// Shared types and helpers for param_data_memory.
//   state_t     : sequencer state (INIT runs the preset fill, READY serves requests)
//   preset_word : word written at a given index by the INIT fill
package param_data_memory_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Lower half holds its own index; upper half holds -k for index DEPTH/2+k.
  // The result is masked to dw bits so callers can truncate without loss.
  function automatic logic [31:0] preset_word(input int idx, input int depth, input int dw);
    logic [31:0] val;
    logic [31:0] mask;
    if (idx < depth / 2) val = 32'(idx);
    else                 val = 32'(-(idx - depth / 2));
    mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    return val & mask;
  endfunction

endpackage

// File: rtl/param_data_memory_array.sv
// DEPTH x DATA_WIDTH storage, one synchronous write port and one synchronous
// read port, no reset so it maps onto block RAM. Read is read-before-write.
//   clock : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates only when re is high
module param_data_memory_array
  import param_data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_data_memory.sv
// Parameterised data memory with a preset sequencer.
// After reset the INIT sequencer fills every word with its preset value (one
// word per cycle, busy high); afterwards READY serves reads and writes.
//   clock, clear_n                 : clock, async active-low reset
//   signal_memread/signal_memwrite : request strobes, sampled every cycle
//   address, data_to_write         : request address and write data
//   data_out, data_valid           : read data (1-cycle latency) and its pulse
//   busy                           : sequencer running, requests refused
//   reject                         : pulse, a request arrived while busy
//   addr_error                     : pulse, out-of-range request while ready
module param_data_memory
  import param_data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  signal_memread,
  input  logic                  signal_memwrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_to_write,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  reject,
  output logic                  addr_error
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  logic                  in_init, in_ready, req, addr_ok;
  logic                  rd_ok, wr_ok;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic                  rd_seen;

  assign in_init  = (state_q == INIT);
  assign in_ready = (state_q == READY);
  assign req      = signal_memread | signal_memwrite;
  // Extra bit so DEPTH itself is representable when DEPTH is a power of two.
  assign addr_ok  = ({1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH));

  // A bad address discards both request types carried in that cycle.
  assign rd_ok = in_ready & signal_memread  & addr_ok;
  assign wr_ok = in_ready & signal_memwrite & addr_ok;

  // Write port mux: preset fill during INIT, user writes in READY. Gating
  // with clear_n drops any write coinciding with an asserted reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = data_to_write;
    if (in_init) begin
      mem_we    = clear_n;
      mem_waddr = idx_q;
      mem_wdata = DATA_WIDTH'(preset_word(int'(idx_q), DEPTH, DATA_WIDTH));
    end else begin
      mem_we    = wr_ok & clear_n;
    end
  end

  // Sequencer
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = READY;
        idx_d   = '0;
      end else begin
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  // Flags. rd_seen masks the un-reset RAM output so data_out reads zero
  // until the first accepted read after reset.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      data_valid <= 1'b0;
      reject     <= 1'b0;
      addr_error <= 1'b0;
      rd_seen    <= 1'b0;
    end else begin
      data_valid <= rd_ok;
      reject     <= in_init & req;
      addr_error <= in_ready & req & ~addr_ok;
      rd_seen    <= rd_seen | rd_ok;
    end
  end

  assign busy     = in_init;
  assign data_out = rd_seen ? mem_rdata : '0;

  param_data_memory_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clock(clock),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (rd_ok),
    .raddr(address),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory: DEPTH=32 main instance plus a DEPTH=24
// instance sharing the same stimulus for the out-of-range address cases.
module tb_param_data_memory;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       signal_memread = 1'b0;
  logic       signal_memwrite = 1'b0;
  logic [4:0] address = '0;
  logic [7:0] data_to_write = '0;

  logic [7:0] data_out,  data_out1;
  logic       data_valid, data_valid1;
  logic       busy, busy1;
  logic       reject, reject1;
  logic       addr_error, addr_error1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  param_data_memory #(.DATA_WIDTH(8), .DEPTH(32)) dut (
    .clock(clock), .clear_n(clear_n),
    .signal_memread(signal_memread), .signal_memwrite(signal_memwrite),
    .address(address), .data_to_write(data_to_write),
    .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .reject(reject), .addr_error(addr_error)
  );

  param_data_memory #(.DATA_WIDTH(8), .DEPTH(24)) dut24 (
    .clock(clock), .clear_n(clear_n),
    .signal_memread(signal_memread), .signal_memwrite(signal_memwrite),
    .address(address), .data_to_write(data_to_write),
    .data_out(data_out1), .data_valid(data_valid1), .busy(busy1),
    .reject(reject1), .addr_error(addr_error1)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    signal_memread = 1'b1;
    address = a;
    tick();
    signal_memread = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    signal_memwrite = 1'b1;
    address = a;
    data_to_write = d;
    tick();
    signal_memwrite = 1'b0;
  endtask

  // Counts cycles (starting from 'start') until each instance drops busy.
  task automatic wait_ready(input int start, output int n0, output int n1);
    int n;
    n = start;
    n0 = busy  ? 0 : n;
    n1 = busy1 ? 0 : n;
    while ((busy || busy1) && n < 200) begin
      tick();
      n++;
      if (!busy  && n0 == 0) n0 = n;
      if (!busy1 && n1 == 0) n1 = n;
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({data_out, data_valid, busy, reject, addr_error} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h vld=%b busy=%b rej=%b aerr=%b want 00 0 1 0 0",
               data_out, data_valid, busy, reject, addr_error);
    end
  endtask

  task automatic test_preset();
    int n0, n1;
    tick();
    clear_n = 1'b1;
    wait_ready(0, n0, n1);
    n_tests++;
    if (n0 !== 32) begin n_fail++; $display("FAIL busy_len32: got %0d want 32", n0); end
    n_tests++;
    if (n1 !== 24) begin n_fail++; $display("FAIL busy_len24: got %0d want 24", n1); end
    rd(5'd17);
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'hFF) begin
      n_fail++; $display("FAIL preset_17: got vld=%b out=%h want 1 ff", data_valid, data_out);
    end
    rd(5'd5);
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'h05) begin
      n_fail++; $display("FAIL preset_5: got vld=%b out=%h want 1 05", data_valid, data_out);
    end
    rd(5'd31);
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'hF1) begin
      n_fail++; $display("FAIL preset_31: got vld=%b out=%h want 1 f1", data_valid, data_out);
    end
    tick();
    n_tests++;
    if (data_valid !== 1'b0 || data_out !== 8'hF1 || reject !== 1'b0 || addr_error !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: got vld=%b out=%h rej=%b aerr=%b want 0 f1 0 0",
                         data_valid, data_out, reject, addr_error);
    end
  endtask

  task automatic test_write_read();
    wr(5'd3, 8'hA5);
    n_tests++;
    if (data_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_no_valid: got %b want 0", data_valid);
    end
    rd(5'd3);
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
      n_fail++; $display("FAIL write_read: got vld=%b out=%h want 1 a5", data_valid, data_out);
    end
  endtask

  task automatic test_rw_same();
    signal_memread = 1'b1;
    signal_memwrite = 1'b1;
    address = 5'd5;
    data_to_write = 8'h3C;
    tick();
    signal_memread = 1'b0;
    signal_memwrite = 1'b0;
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'h05) begin
      n_fail++; $display("FAIL rw_old_data: got vld=%b out=%h want 1 05", data_valid, data_out);
    end
    rd(5'd5);
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
      n_fail++; $display("FAIL rw_new_data: got vld=%b out=%h want 1 3c", data_valid, data_out);
    end
  endtask

  task automatic test_init_request();
    int n0, n1;
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    repeat (10) tick();
    signal_memread = 1'b1;
    signal_memwrite = 1'b1;
    address = 5'd0;
    data_to_write = 8'h77;
    tick();
    signal_memread = 1'b0;
    signal_memwrite = 1'b0;
    n_tests++;
    if (reject !== 1'b1 || data_valid !== 1'b0 || addr_error !== 1'b0) begin
      n_fail++; $display("FAIL init_reject: got rej=%b vld=%b aerr=%b want 1 0 0",
                         reject, data_valid, addr_error);
    end
    tick();
    n_tests++;
    if (reject !== 1'b0) begin n_fail++; $display("FAIL reject_once: got %b want 0", reject); end
    wait_ready(12, n0, n1);
    n_tests++;
    if (n0 !== 32) begin n_fail++; $display("FAIL init_busy_len: got %0d want 32", n0); end
    rd(5'd0);
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL init_write_dropped: got vld=%b out=%h want 1 00", data_valid, data_out);
    end
  endtask

  task automatic test_reset_mid_init();
    int n0, n1;
    wr(5'd3, 8'hA5);
    rd(5'd3);
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
      n_fail++; $display("FAIL pre_reset_write: got vld=%b out=%h want 1 a5", data_valid, data_out);
    end
    clear_n = 1'b0;
    #1;
    n_tests++;
    if ({data_out, data_valid, busy, reject, addr_error} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got out=%h vld=%b busy=%b rej=%b aerr=%b want 00 0 1 0 0",
               data_out, data_valid, busy, reject, addr_error);
    end
    tick();
    clear_n = 1'b1;
    repeat (10) tick();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    wait_ready(0, n0, n1);
    n_tests++;
    if (n0 !== 32) begin n_fail++; $display("FAIL restart_busy_len: got %0d want 32", n0); end
    rd(5'd3);
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'h03) begin
      n_fail++; $display("FAIL preset_restored: got vld=%b out=%h want 1 03", data_valid, data_out);
    end
  endtask

  task automatic test_depth24();
    rd(5'd23);
    n_tests++;
    if (data_valid1 !== 1'b1 || data_out1 !== 8'hF5) begin
      n_fail++; $display("FAIL d24_read23: got vld=%b out=%h want 1 f5", data_valid1, data_out1);
    end
    rd(5'd30);
    n_tests++;
    if (addr_error1 !== 1'b1 || data_valid1 !== 1'b0 || data_out1 !== 8'hF5 || reject1 !== 1'b0) begin
      n_fail++; $display("FAIL d24_addr_error: got aerr=%b vld=%b out=%h rej=%b want 1 0 f5 0",
                         addr_error1, data_valid1, data_out1, reject1);
    end
    signal_memread = 1'b1;
    signal_memwrite = 1'b1;
    address = 5'd30;
    data_to_write = 8'h55;
    tick();
    signal_memread = 1'b0;
    signal_memwrite = 1'b0;
    n_tests++;
    if (addr_error1 !== 1'b1 || data_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL d24_rw_bad: got aerr=%b vld=%b want 1 0", addr_error1, data_valid1);
    end
    tick();
    n_tests++;
    if (addr_error1 !== 1'b0) begin
      n_fail++; $display("FAIL d24_aerr_pulse: got %b want 0", addr_error1);
    end
    rd(5'd12);
    n_tests++;
    if (data_valid1 !== 1'b1 || data_out1 !== 8'h00) begin
      n_fail++; $display("FAIL d24_read12: got vld=%b out=%h want 1 00", data_valid1, data_out1);
    end
  endtask

  initial begin
    test_reset();
    test_preset();
    test_write_read();
    test_rw_same();
    test_init_request();
    test_reset_mid_init();
    test_depth24();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
